// File: rtl/bcd_scan_ctrl.sv
// Sequential double-dabble BCD converter with a multiplexed common-anode 7-segment scan.
// Define BCD_LZB_EN to blank leading zeros on the display (ones digit never blanked).
module bcd_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] digits,
  output logic [4:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] shreg;
  logic [19:0] work;
  logic [3:0]  count;
  logic [19:0] work_adj;
  logic [19:0] work_nxt;
  logic [15:0] shreg_nxt;
  logic        last_shift;
  logic        accept;

  logic [15:0] scan_cnt;
  logic [2:0]  index;
  logic        scan_wrap;
  logic [3:0]  sel_nib;
  logic        blank;

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT:   state_nxt = last_shift ? DONE : SHIFT;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Double-dabble datapath: add-3 correction on every nibble, then shift
  // ---------------------------------------------------------------------------
  always_comb begin
    work_adj = work;
    for (int unsigned i = 0; i < 5; i++) begin
      if (work[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
    end
    work_nxt  = {work_adj[18:0], shreg[15]};
    shreg_nxt = {shreg[14:0], 1'b0};
  end

  assign accept     = (state != SHIFT) && start;
  assign last_shift = (state == SHIFT) && (count == 4'd15);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shreg <= '0;
      work  <= '0;
      count <= '0;
    end else if (accept) begin
      shreg <= bin;
      work  <= '0;
      count <= '0;
    end else if (state == SHIFT) begin
      shreg <= shreg_nxt;
      work  <= work_nxt;
      count <= count + 4'd1;
    end
  end

  // Result is captured from the final shift itself so it is valid in the DONE cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      digits <= '0;
    end else if (last_shift) begin
      digits <= work_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan, free-running and independent of the converter
  // ---------------------------------------------------------------------------
  assign scan_wrap = (scan_cnt == SCAN_LAST);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      scan_cnt <= '0;
      index    <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      index    <= (index == 3'd4) ? 3'd0 : index + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  always_comb begin
    sel_nib = '0;
    case (index)
      3'd0:    sel_nib = digits[3:0];
      3'd1:    sel_nib = digits[7:4];
      3'd2:    sel_nib = digits[11:8];
      3'd3:    sel_nib = digits[15:12];
      3'd4:    sel_nib = digits[19:16];
      default: sel_nib = '0;
    endcase
  end

`ifdef BCD_LZB_EN
  // A position is blank when it and every position above it hold zero.
  always_comb begin
    blank = 1'b0;
    case (index)
      3'd1:    blank = (digits[19:4]  == '0);
      3'd2:    blank = (digits[19:8]  == '0);
      3'd3:    blank = (digits[19:12] == '0);
      3'd4:    blank = (digits[19:16] == '0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an  = ~(5'b00001 << index);
    seg = 7'h7F;
    if (!blank) begin
      case (sel_nib)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = 7'h7F;
      endcase
    end
  end

endmodule
